// File: rtl/rgb_seq_pkg.sv
// ============================================================================
// Module   : rgb_seq_pkg
// Brief    : Shared phase constants, channel lookups and default timing for
//            the rainbow LED colour-wheel sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rgb_seq_pkg;

    // Channel vectors are ordered {B, G, R}: bit 0 = R, bit 1 = G, bit 2 = B
    typedef logic [2:0] rgb_t;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;

    localparam int DEBOUNCE_CYC_DEF = 1_000_000;
    localparam int WDOG_CYC_DEF     = 48_000_000;

    function automatic rgb_t up_mask(input logic [1:0] ph);
        rgb_t m;
        case (ph)
            PH0:     m = 3'b001;
            PH1:     m = 3'b010;
            PH2:     m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // The illegal encoding darkens every channel for its single cycle
    function automatic rgb_t dark_mask(input logic [1:0] ph);
        rgb_t m;
        case (ph)
            PH0:     m = 3'b010;
            PH1:     m = 3'b100;
            PH2:     m = 3'b001;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_seq_if.sv
// ============================================================================
// Module   : rgb_seq_if
// Brief    : Channel status/PWM inputs, LED/flag outputs and button signals
//            between the sequencer and its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgb_seq_if;

    logic       BTN;
    logic       STT_R, STT_G, STT_B;
    logic       PWM_R, PWM_G, PWM_B;
    logic       FLAG_R, FLAG_G, FLAG_B;
    logic       LED_R, LED_G, LED_B;
    logic       BP;
    logic [1:0] PHASE;
    logic       WDOG_HIT;

    modport master (
        output BTN, STT_R, STT_G, STT_B, PWM_R, PWM_G, PWM_B,
        input  FLAG_R, FLAG_G, FLAG_B, LED_R, LED_G, LED_B, BP, PHASE, WDOG_HIT
    );

    modport slave (
        input  BTN, STT_R, STT_G, STT_B, PWM_R, PWM_G, PWM_B,
        output FLAG_R, FLAG_G, FLAG_B, LED_R, LED_G, LED_B, BP, PHASE, WDOG_HIT
    );

endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchronizer, stability counter and one-cycle press
//            pulse for an asynchronous active-high button.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_btn,
    output logic      o_bp
);

    localparam int                 c_cnt_w   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYC - 1);

    logic               sync1_q, sync2_q;
    logic               acc_q, acc_d;
    logic               acc_prev_q;
    logic               bp_q, bp_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        bp_d  = acc_q & ~acc_prev_q;
        // Count only while the synchronized level disagrees with the accepted one
        if (sync2_q != acc_q) begin
            if (cnt_q == c_cnt_max) begin
                acc_d = sync2_q;
            end else begin
                cnt_d = cnt_q + c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            acc_q      <= 1'b0;
            acc_prev_q <= 1'b0;
            bp_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= i_btn;
            sync2_q    <= sync1_q;
            acc_q      <= acc_d;
            acc_prev_q <= acc_q;
            bp_q       <= bp_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_bp = bp_q;

endmodule

`default_nettype wire

// File: rtl/rgb_sequencer.sv
// ============================================================================
// Module   : rgb_sequencer
// Brief    : 3-phase colour-wheel crossfade sequencer for the RGB breathing
//            channels, with debounced speed button. Optional watchdog advance
//            is compiled in with RGB_SEQ_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int WDOG_CYC     = WDOG_CYC_DEF
) (
    input  wire logic   CLK,
    input  wire logic   RST_N,
    rgb_seq_if.slave    bus
);

    logic [1:0] phase_q, phase_d;
    rgb_t       flag_q, flag_d;
    rgb_t       led_q, led_d;
    rgb_t       stt_prev_q;
    rgb_t       w_stt, w_pwm;
    logic       w_edge, w_advance, w_wdog_fire;

    assign w_stt = {bus.STT_B, bus.STT_G, bus.STT_R};
    assign w_pwm = {bus.PWM_B, bus.PWM_G, bus.PWM_R};

    always_comb begin
        w_edge    = |(w_stt & ~stt_prev_q & up_mask(phase_q));
        w_advance = w_edge | w_wdog_fire;
        phase_d   = phase_q;
        if (phase_q > PH2) begin
            phase_d = PH0;
        end else if (w_advance) begin
            phase_d = (phase_q == PH2) ? PH0 : phase_q + 2'd1;
        end
        flag_d = up_mask(phase_d);
        led_d  = w_pwm & ~dark_mask(phase_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_q    <= PH0;
            flag_q     <= 3'b001;
            led_q      <= '0;
            stt_prev_q <= '0;
        end else begin
            phase_q    <= phase_d;
            flag_q     <= flag_d;
            led_q      <= led_d;
            stt_prev_q <= w_stt;
        end
    end

`ifdef RGB_SEQ_WATCHDOG_EN
    localparam int                  c_wdog_w   = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [c_wdog_w-1:0] c_wdog_max = c_wdog_w'(WDOG_CYC - 1);

    logic [c_wdog_w-1:0] wdog_cnt_q, wdog_cnt_d;
    logic                wdog_hit_q, wdog_hit_d;

    always_comb begin
        w_wdog_fire = (wdog_cnt_q == c_wdog_max);
        wdog_cnt_d  = (w_edge | w_wdog_fire) ? '0 : wdog_cnt_q + c_wdog_w'(1);
        wdog_hit_d  = wdog_hit_q | w_wdog_fire;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wdog_cnt_q <= '0;
            wdog_hit_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_hit_q <= wdog_hit_d;
        end
    end

    assign bus.WDOG_HIT = wdog_hit_q;
`else
    assign w_wdog_fire  = 1'b0;
    assign bus.WDOG_HIT = 1'b0;
`endif

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk   (CLK),
        .rst_n (RST_N),
        .i_btn (bus.BTN),
        .o_bp  (bus.BP)
    );

    assign bus.PHASE  = phase_q;
    assign bus.FLAG_R = flag_q[0];
    assign bus.FLAG_G = flag_q[1];
    assign bus.FLAG_B = flag_q[2];
    assign bus.LED_R  = led_q[0];
    assign bus.LED_G  = led_q[1];
    assign bus.LED_B  = led_q[2];

endmodule

`default_nettype wire

// File: tb/tb_rgb_sequencer.sv
// ============================================================================
// Module   : tb_rgb_sequencer
// Brief    : Directed self-checking bench for rgb_sequencer
//            (DEBOUNCE_CYC=4, WDOG_CYC=100).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb_sequencer;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    rgb_seq_if bus ();

    rgb_sequencer #(
        .DEBOUNCE_CYC (4),
        .WDOG_CYC     (100)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.BTN   = 1'b0;
        bus.STT_R = 1'b0;
        bus.STT_G = 1'b0;
        bus.STT_B = 1'b0;
        bus.PWM_R = 1'b0;
        bus.PWM_G = 1'b0;
        bus.PWM_B = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [2:0] flags();
        return {bus.FLAG_B, bus.FLAG_G, bus.FLAG_R};
    endfunction

    function automatic logic [2:0] leds();
        return {bus.LED_B, bus.LED_G, bus.LED_R};
    endfunction

    logic [7:0] pat;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_inputs();

        // Reset state, idle
        do_reset();
        tick();
        check_vec("rst_phase", bus.PHASE, 8'd0);
        check_vec("rst_flag", flags(), 8'b001);
        check_vec("rst_led", leds(), 8'b000);
        check_vec("rst_bp", bus.BP, 8'd0);
        check_vec("rst_wdog", bus.WDOG_HIT, 8'd0);

        // STT_R already high at reset release counts as an edge
        rst_n = 1'b0;
        bus.STT_R = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_vec("stt_at_release", bus.PHASE, 8'd1);

        // Full wheel: PH0 -> PH1 -> PH2 -> PH0
        do_reset();
        bus.PWM_R = 1'b1;
        bus.STT_R = 1'b1;
        tick();
        check_vec("ph0_to_ph1", bus.PHASE, 8'd1);
        check_vec("flag_ph1", flags(), 8'b010);
        repeat (9) tick();
        check_vec("held_r_once", bus.PHASE, 8'd1);
        bus.STT_R = 1'b0;
        tick();
        bus.STT_R = 1'b1;
        tick();
        check_vec("ignore_down_r", bus.PHASE, 8'd1);
        bus.STT_R = 1'b0;
        bus.STT_G = 1'b1;
        tick();
        check_vec("ph1_to_ph2", bus.PHASE, 8'd2);
        check_vec("flag_ph2", flags(), 8'b100);
        check_vec("led_r_lag", bus.LED_R, 8'd1);
        tick();
        check_vec("led_r_dark", bus.LED_R, 8'd0);
        bus.STT_G = 1'b0;
        bus.STT_B = 1'b1;
        tick();
        check_vec("ph2_to_ph0", bus.PHASE, 8'd0);
        check_vec("flag_ph0", flags(), 8'b001);

        // PH0 ignores G/B edges; G dark, R follows PWM one cycle later
        do_reset();
        bus.STT_G = 1'b1;
        bus.STT_B = 1'b1;
        tick();
        check_vec("ignore_gb", bus.PHASE, 8'd0);
        bus.STT_G = 1'b0;
        bus.STT_B = 1'b0;
        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            bus.PWM_R = pat[i];
            bus.PWM_G = i[0];
            tick();
            check_vec("led_r_follow", bus.LED_R, {7'd0, pat[i]});
            check_vec("led_g_dark", bus.LED_G, 8'd0);
        end

        // Button: short glitches, then a stable press and release
        do_reset();
        for (int g = 0; g < 2; g++) begin
            bus.BTN = 1'b1;
            repeat (2) begin
                tick();
                check_vec("bp_glitch", bus.BP, 8'd0);
            end
            bus.BTN = 1'b0;
            repeat (3) begin
                tick();
                check_vec("bp_glitch", bus.BP, 8'd0);
            end
        end
        bus.BTN = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_vec("bp_press", bus.BP, (i == 7) ? 8'd1 : 8'd0);
        end
        bus.BTN = 1'b0;
        repeat (10) begin
            tick();
            check_vec("bp_release", bus.BP, 8'd0);
        end

        // Watchdog
        do_reset();
`ifdef RGB_SEQ_WATCHDOG_EN
        repeat (99) tick();
        check_vec("wdog_pre_phase", bus.PHASE, 8'd0);
        check_vec("wdog_pre_hit", bus.WDOG_HIT, 8'd0);
        tick();
        check_vec("wdog_phase", bus.PHASE, 8'd1);
        check_vec("wdog_hit", bus.WDOG_HIT, 8'd1);
        repeat (5) tick();
        check_vec("wdog_sticky", bus.WDOG_HIT, 8'd1);
`else
        repeat (120) tick();
        check_vec("nowdog_phase", bus.PHASE, 8'd0);
        check_vec("nowdog_hit", bus.WDOG_HIT, 8'd0);
`endif

        // Asynchronous reset mid-PH2 while the button is debouncing
        do_reset();
        bus.STT_R = 1'b1;
        tick();
        bus.STT_R = 1'b0;
        bus.STT_G = 1'b1;
        tick();
        bus.STT_G = 1'b0;
        check_vec("mid_ph2", bus.PHASE, 8'd2);
        bus.BTN   = 1'b1;
        bus.PWM_B = 1'b1;
        bus.PWM_G = 1'b1;
        repeat (4) tick();
        check_vec("mid_led", leds(), 8'b110);
        rst_n = 1'b0;
        #1;
        check_vec("async_phase", bus.PHASE, 8'd0);
        check_vec("async_flag", flags(), 8'b001);
        check_vec("async_led", leds(), 8'b000);
        check_vec("async_bp", bus.BP, 8'd0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            check_vec("bp_after_rst", bus.BP, 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
